// File: rtl/register_file_pkg.sv
// Shared widths and bus types for the architectural register file
// and its rename-tag table.
package register_file_pkg;

  localparam int REG_BIT = 5;
  localparam int ROB_BIT = 5;
  localparam int DAT_W   = 32;
  localparam int REG_S   = 32;

  typedef logic [REG_BIT-1:0] reg_t;
  typedef logic [ROB_BIT-1:0] rob_t;
  typedef logic [DAT_W-1:0]   dat_t;

endpackage

// File: rtl/register_file_if.sv
// Issue, commit, ROB-lookup and operand buses of the register file.
// master drives issue/commit; slave is the register file itself.
interface register_file_if;
  import register_file_pkg::*;

  logic is_en_i;
  reg_t is_rs1_i;
  reg_t is_rs2_i;
  reg_t is_rd_i;
  rob_t is_q_i;

  logic cmt_en_i;
  reg_t cmt_rd_i;
  rob_t cmt_q_i;
  dat_t cmt_v_i;

  rob_t rob_reqqj_o;
  rob_t rob_reqqk_o;
  logic rob_rdyj_i;
  logic rob_rdyk_i;
  dat_t rob_rdyvj_i;
  dat_t rob_rdyvk_i;

  rob_t qj_o;
  rob_t qk_o;
  dat_t vj_o;
  dat_t vk_o;

  modport master (
    output is_en_i, is_rs1_i, is_rs2_i,
    output is_rd_i, is_q_i,
    output cmt_en_i, cmt_rd_i, cmt_q_i,
    output cmt_v_i,
    output rob_rdyj_i, rob_rdyk_i,
    output rob_rdyvj_i, rob_rdyvk_i,
    input  rob_reqqj_o, rob_reqqk_o,
    input  qj_o, qk_o, vj_o, vk_o
  );

  modport slave (
    input  is_en_i, is_rs1_i, is_rs2_i,
    input  is_rd_i, is_q_i,
    input  cmt_en_i, cmt_rd_i, cmt_q_i,
    input  cmt_v_i,
    input  rob_rdyj_i, rob_rdyk_i,
    input  rob_rdyvj_i, rob_rdyvk_i,
    output rob_reqqj_o, rob_reqqk_o,
    output qj_o, qk_o, vj_o, vk_o
  );

endinterface

// File: rtl/register_file_rf_read_port.sv
// One operand read port: value, commit bypass,
// ROB-ready bypass, or pending tag.
module rf_read_port
  import register_file_pkg::*;
(
  input  reg_t i_rs,
  input  rob_t i_tag,
  input  dat_t i_val,
  input  logic i_cmt_en,
  input  rob_t i_cmt_q,
  input  dat_t i_cmt_v,
  input  logic i_rdy,
  input  dat_t i_rdyv,
  output rob_t o_q,
  output dat_t o_v,
  output rob_t o_req
);

  logic w_zero;
  assign w_zero = (i_rs == '0);
  assign o_req  = w_zero ? '0 : i_tag;

  always_comb begin
    o_q = '0;
    o_v = '0;
    if (w_zero) begin
      o_q = '0;
      o_v = '0;
    end else if (i_tag == '0) begin
      o_v = i_val;
    end else if (i_cmt_en && i_cmt_q == i_tag) begin
      o_v = i_cmt_v;
    end else if (i_rdy) begin
      o_v = i_rdyv;
    end else begin
      o_q = i_tag;
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with rename tags, fed by issue
// and by the ROB commit port; flush drops every tag.
module register_file
  import register_file_pkg::*;
(
  input logic clk,
  input logic rst_n,
  input logic en,
  input logic flush_i,
  register_file_if.slave bus
);

  dat_t r_val [REG_S];
  rob_t r_tag [REG_S];

  logic w_cmt_wr;
  logic w_is_wr;

  assign w_cmt_wr = bus.cmt_en_i
                 && (bus.cmt_rd_i != '0);
  assign w_is_wr  = bus.is_en_i
                 && (bus.is_rd_i != '0)
                 && !flush_i;

  // Later assignments win: flush over issue over commit clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_S; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
    end else if (en) begin
      if (w_cmt_wr) begin
        r_val[bus.cmt_rd_i] <= bus.cmt_v_i;
        if (r_tag[bus.cmt_rd_i] == bus.cmt_q_i)
          r_tag[bus.cmt_rd_i] <= '0;
      end
      if (flush_i) begin
        for (int i = 0; i < REG_S; i++)
          r_tag[i] <= '0;
      end else if (w_is_wr) begin
        r_tag[bus.is_rd_i] <= bus.is_q_i;
      end
    end
  end

  rf_read_port u_port_j (
    .i_rs     (bus.is_rs1_i),
    .i_tag    (r_tag[bus.is_rs1_i]),
    .i_val    (r_val[bus.is_rs1_i]),
    .i_cmt_en (bus.cmt_en_i),
    .i_cmt_q  (bus.cmt_q_i),
    .i_cmt_v  (bus.cmt_v_i),
    .i_rdy    (bus.rob_rdyj_i),
    .i_rdyv   (bus.rob_rdyvj_i),
    .o_q      (bus.qj_o),
    .o_v      (bus.vj_o),
    .o_req    (bus.rob_reqqj_o)
  );

  rf_read_port u_port_k (
    .i_rs     (bus.is_rs2_i),
    .i_tag    (r_tag[bus.is_rs2_i]),
    .i_val    (r_val[bus.is_rs2_i]),
    .i_cmt_en (bus.cmt_en_i),
    .i_cmt_q  (bus.cmt_q_i),
    .i_cmt_v  (bus.cmt_v_i),
    .i_rdy    (bus.rob_rdyk_i),
    .i_rdyv   (bus.rob_rdyvk_i),
    .o_q      (bus.qk_o),
    .o_v      (bus.vk_o),
    .o_req    (bus.rob_reqqk_o)
  );

endmodule
